booth_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-cycle Booth multiplier between `N_REQ` requesters. It accepts operand pairs through per-requester valid/ready handshakes and launches the multiplier with a one-cycle start pulse. It waits for the multiplier's done strobe, with a watchdog, and returns the product on a single tagged response channel. It sits between the client logic and the multiplier core. Only one multiplication is in flight at a time.

---
 rtl/booth_mul_arbiter_if.sv | 30 +++
 rtl/booth_mul_arbiter.sv | 152 +++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_arbiter_if.sv
// Request/response bundle between the client requesters and booth_mul_arbiter.
// The master side is the client logic; the slave side is the arbiter.
interface booth_mul_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) ();
    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam int unsigned PW   = 2 * WIDTH;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [PW-1:0]          rsp_product;
    logic                   rsp_err;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle Booth multiplier between
// N_REQ requesters, with a done-strobe watchdog and a tagged response channel.
module booth_mul_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    booth_mul_arbiter_if.slave     bus,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic                   mul_done,
    input  logic [2*WIDTH-1:0]     mul_product
);
    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] last_grant, last_grant_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] mul_a_nxt, mul_b_nxt;
    logic            rsp_valid_q, rsp_valid_nxt;
    logic            rsp_err_q, rsp_err_nxt;
    logic [ID_W-1:0] rsp_id_q, rsp_id_nxt;
    logic [PW-1:0]   rsp_product_q, rsp_product_nxt;

    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] scan_idx;
    logic            grant_found;
    logic            fire;

    logic [WIDTH-1:0] a_arr [N_REQ];
    logic [WIDTH-1:0] b_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = bus.req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = bus.req_b[g*WIDTH +: WIDTH];
    end

    // First valid requester searching upward from the one after last_grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            scan_idx = ID_W'((32'(last_grant) + i) % N_REQ);
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign fire          = (state == IDLE) && ena && grant_found;
    assign bus.req_ready = fire ? (N_REQ'(1) << grant_idx) : '0;
    // Held low while disabled so a frozen ISSUE cycle re-launches once ena returns.
    assign mul_start     = (state == ISSUE) && ena;

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_product = rsp_product_q;
    assign bus.rsp_err     = rsp_err_q;

    // Next-state and registered-output logic; everything holds while ena is low.
    always_comb begin
        state_nxt       = state;
        last_grant_nxt  = last_grant;
        cnt_nxt         = cnt;
        mul_a_nxt       = mul_a;
        mul_b_nxt       = mul_b;
        rsp_valid_nxt   = rsp_valid_q;
        rsp_err_nxt     = rsp_err_q;
        rsp_id_nxt      = rsp_id_q;
        rsp_product_nxt = rsp_product_q;

        if (ena) begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        mul_a_nxt      = a_arr[grant_idx];
                        mul_b_nxt      = b_arr[grant_idx];
                        rsp_id_nxt     = grant_idx;
                        last_grant_nxt = grant_idx;
                        state_nxt      = ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT;
                end
                WAIT: begin
                    // A done strobe on the watchdog cycle takes priority over the abort.
                    if (mul_done) begin
                        rsp_product_nxt = mul_product;
                        rsp_err_nxt     = 1'b0;
                        rsp_valid_nxt   = 1'b1;
                        state_nxt       = RESP;
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        rsp_product_nxt = '0;
                        rsp_err_nxt     = 1'b1;
                        rsp_valid_nxt   = 1'b1;
                        state_nxt       = RESP;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_nxt = 1'b0;
                        state_nxt     = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= ID_W'(N_REQ - 1);
            cnt           <= '0;
            mul_a         <= '0;
            mul_b         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
        end else begin
            state         <= state_nxt;
            last_grant    <= last_grant_nxt;
            cnt           <= cnt_nxt;
            mul_a         <= mul_a_nxt;
            mul_b         <= mul_b_nxt;
            rsp_valid_q   <= rsp_valid_nxt;
            rsp_err_q     <= rsp_err_nxt;
            rsp_id_q      <= rsp_id_nxt;
            rsp_product_q <= rsp_product_nxt;
        end
    end
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter: a vector table of single operations plus
// hand-written round-robin, enable, late-done and reset sequences.
module tb_booth_mul_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned TO = 31;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena = 1'b1;
    logic           mul_start;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_done = 1'b0;
    logic [2*W-1:0] mul_product = '0;

    int n_pass  = 0;
    int n_total = 0;

    booth_mul_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    booth_mul_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .bus         (bus),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_product (mul_product)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        int          lat;
        bit          done;
        int          hold;
        logic [15:0] prod;
        bit          err;
        int          cyc;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Inputs are driven at negedge+1 and outputs sampled at negedge+2.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset(input bit check);
        rst_n = 1'b0;
        ena = 1'b1;
        mul_done = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        if (check) begin
            chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
            chk("rst_mul_start", 32'(mul_start), 32'd0);
            chk("rst_mul_a", 32'(mul_a), 32'd0);
            chk("rst_mul_b", 32'(mul_b), 32'd0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
            chk("rst_rsp_product", 32'(bus.rsp_product), 32'd0);
            chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        end
        rst_n = 1'b1;
    endtask

    // Multiplier stand-in: signed product of the operands the DUT presents.
    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] pa;
        logic signed [15:0] pb;
        pa = 16'($signed(a));
        pb = 16'($signed(b));
        return 16'(pa * pb);
    endfunction

    // One complete operation starting in IDLE; handshake is cycle 0.
    task automatic run_op(input int idx, input vec_t v);
        int cyc;
        bit got;
        int stray;
        string p;
        p = $sformatf("v%0d_", idx);
        bus.rsp_ready = (v.hold == 0);
        bus.req_valid = '0;
        bus.req_valid[v.id] = 1'b1;
        bus.req_a[v.id*W +: W] = v.a;
        bus.req_b[v.id*W +: W] = v.b;
        #1;
        chk({p, "req_ready"}, 32'(bus.req_ready), 32'd1 << v.id);
        tick();
        bus.req_valid = '0;
        bus.req_a[v.id*W +: W] = ~v.a;
        bus.req_b[v.id*W +: W] = ~v.b;
        #1;
        chk({p, "mul_start"}, 32'(mul_start), 32'd1);
        chk({p, "mul_a"}, 32'(mul_a), 32'(v.a));
        chk({p, "mul_b"}, 32'(mul_b), 32'(v.b));
        cyc = 1;
        got = 1'b0;
        stray = 0;
        while (!got && cyc < 100) begin
            tick();
            cyc++;
            mul_done = v.done && (cyc == 1 + v.lat);
            mul_product = mul_done ? smul(mul_a, mul_b) : 16'hA5A5;
            #1;
            if (mul_start) stray++;
            got = bus.rsp_valid;
        end
        mul_done = 1'b0;
        chk({p, "rsp_cycle"}, 32'(cyc), 32'(v.cyc));
        chk({p, "extra_start"}, 32'(stray), 32'd0);
        chk({p, "rsp_id"}, 32'(bus.rsp_id), 32'(v.id));
        chk({p, "rsp_product"}, 32'(bus.rsp_product), 32'(v.prod));
        chk({p, "rsp_err"}, 32'(bus.rsp_err), 32'(v.err));
        for (int k = 1; k <= v.hold; k++) begin
            tick();
            bus.rsp_ready = (k == v.hold);
            bus.req_valid = '1;
            #1;
            chk({p, "bp_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({p, "bp_id"}, 32'(bus.rsp_id), 32'(v.id));
            chk({p, "bp_product"}, 32'(bus.rsp_product), 32'(v.prod));
            chk({p, "bp_req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        #1;
        chk({p, "rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int c;
        bit got;
        int starts;
        int busy;
        int exp_id;

        vecs[0] = '{2, 8'h07, 8'hFD, 10, 1'b1, 0, 16'hFFEB, 1'b0, 12};
        vecs[1] = '{0, 8'hFF, 8'hFF, 1,  1'b1, 0, 16'h0001, 1'b0, 3};
        vecs[2] = '{1, 8'h80, 8'h80, 3,  1'b1, 0, 16'h4000, 1'b0, 5};
        vecs[3] = '{3, 8'h7F, 8'h80, 5,  1'b1, 0, 16'hC080, 1'b0, 7};
        vecs[4] = '{1, 8'h03, 8'hFC, 2,  1'b1, 5, 16'hFFF4, 1'b0, 4};
        vecs[5] = '{0, 8'h12, 8'h34, 31, 1'b1, 0, 16'h03A8, 1'b0, 33};
        vecs[6] = '{0, 8'h12, 8'h34, 32, 1'b1, 0, 16'h03A8, 1'b0, 34};
        vecs[7] = '{3, 8'h55, 8'h66, 0,  1'b0, 0, 16'h0000, 1'b1, 34};

        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        apply_reset(1'b1);

        // Round robin with every requester continuously valid.
        bus.req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            exp_id = k % 4;
            #1;
            chk($sformatf("rr%0d_grant", k), 32'(bus.req_ready), 32'd1 << exp_id);
            c = 0;
            got = 1'b0;
            starts = 0;
            busy = 0;
            while (!got && c < 20) begin
                tick();
                c++;
                mul_done = (c == 2);
                mul_product = 16'(k + 16'h100);
                #1;
                if (mul_start) starts++;
                if (bus.req_ready != '0) busy++;
                got = bus.rsp_valid;
            end
            mul_done = 1'b0;
            chk($sformatf("rr%0d_starts", k), 32'(starts), 32'd1);
            chk($sformatf("rr%0d_busy_ready", k), 32'(busy), 32'd0);
            chk($sformatf("rr%0d_rsp_id", k), 32'(bus.rsp_id), 32'(exp_id));
            chk($sformatf("rr%0d_product", k), 32'(bus.rsp_product), 32'(k + 16'h100));
            tick();
        end
        bus.req_valid = '0;

        for (int i = 0; i < 8; i++) run_op(i, vecs[i]);

        // Late done strobe in IDLE after the watchdog abort must not be latched.
        mul_done = 1'b1;
        mul_product = 16'h1234;
        #1;
        chk("late_done_valid0", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("late_done_valid1", 32'(bus.rsp_valid), 32'd0);
        chk("late_done_product", 32'(bus.rsp_product), 32'd0);
        mul_done = 1'b0;
        tick();

        // Enable low: no accept in IDLE, deferred start, frozen watchdog in WAIT.
        ena = 1'b0;
        bus.req_valid = 4'b0010;
        bus.req_a[1*W +: W] = 8'd5;
        bus.req_b[1*W +: W] = 8'd6;
        #1;
        chk("ena_low_ready", 32'(bus.req_ready), 32'd0);
        tick();
        ena = 1'b1;
        #1;
        chk("ena_grant", 32'(bus.req_ready), 32'b0010);
        for (int k = 1; k <= 3; k++) begin
            tick();
            ena = 1'b0;
            bus.req_valid = '0;
            #1;
            chk($sformatf("ena_defer%0d", k), 32'(mul_start), 32'd0);
        end
        tick();
        ena = 1'b1;
        #1;
        chk("ena_start", 32'(mul_start), 32'd1);
        chk("ena_mul_a", 32'(mul_a), 32'd5);
        c = 4;
        got = 1'b0;
        starts = 0;
        while (!got && c < 100) begin
            tick();
            c++;
            ena = !(c >= 10 && c <= 12);
            #1;
            if (mul_start) starts++;
            got = bus.rsp_valid;
        end
        ena = 1'b1;
        chk("ena_wd_cycle", 32'(c), 32'd40);
        chk("ena_wd_starts", 32'(starts), 32'd0);
        chk("ena_wd_err", 32'(bus.rsp_err), 32'd1);
        chk("ena_wd_id", 32'(bus.rsp_id), 32'd1);
        tick();
        #1;
        chk("ena_rsp_drop", 32'(bus.rsp_valid), 32'd0);

        // Reset while waiting on the multiplier.
        run_op(8, vecs[0]);
        bus.req_valid = 4'b0100;
        bus.req_a[2*W +: W] = 8'd9;
        bus.req_b[2*W +: W] = 8'd9;
        #1;
        chk("rw_grant", 32'(bus.req_ready), 32'b0100);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rw_mul_start", 32'(mul_start), 32'd0);
        chk("rw_mul_a", 32'(mul_a), 32'd0);
        chk("rw_mul_b", 32'(mul_b), 32'd0);
        chk("rw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rw_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rw_rsp_product", 32'(bus.rsp_product), 32'd0);
        chk("rw_rsp_err", 32'(bus.rsp_err), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.req_valid = '1;
        #1;
        chk("rw_next_grant", 32'(bus.req_ready), 32'b0001);
        bus.req_valid = '0;
        tick();
        tick();
        chk("rw_no_rsp", 32'(bus.rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
